// File: rtl/entropy_array_sampler.sv
// entropy_array_sampler
//   Drives an array of N_CELLS entropy cells from a round-based FSM.
//   Each cell output is synchronised and captured, then assembled into an
//   OUT_WIDTH-bit result.
//   Random mode: one parity bit per round.
//   PUF mode: one N_CELLS-bit slice per round.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           one-cycle request, accepted in IDLE only
//   mode            0 = random, 1 = PUF (sampled at start)
//   challenge       PUF challenge (sampled at start)
//   mask            random-mode cell enables (sampled at start)
//   ack             consumer acknowledge of data
//   busy            conversion in progress
//   valid           data holds a complete result
//   data            result word

// Behavioural stand-in for the XOR-latch cell: out = T & I1.
// I2 only selects the cell's silicon operating point, so the model ignores it.
module entropy_cell (
  input  logic t,
  input  logic i1,
  input  logic i2,
  output logic o
);
  logic unused_i2;
  assign unused_i2 = i2;
  assign o = t & i1;
endmodule

module entropy_array_sampler #(
  parameter int N_CELLS       = 8,
  parameter int OUT_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [N_CELLS-1:0]   challenge,
  input  logic [N_CELLS-1:0]   mask,
  input  logic                 ack,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] data
);
  localparam int ROUNDS_RND = OUT_WIDTH;
  localparam int ROUNDS_PUF = OUT_WIDTH / N_CELLS;
  localparam int RW = $clog2(OUT_WIDTH + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, EXCITE, CAPTURE, DONE} state_t;

  state_t             state, nxt;
  logic               t_en;
  logic               mode_q;
  logic [N_CELLS-1:0] mask_q, chal_q;
  logic [N_CELLS-1:0] i1_vec, cell_out, sync1, sync2;
  logic [RW-1:0]      rnd_cnt;
  logic [SW-1:0]      settle_cnt;
  logic               last_round;

  assign i1_vec = mode_q ? chal_q : mask_q;

  entropy_cell u_cell [N_CELLS-1:0] (
    .t  ({N_CELLS{t_en}}),
    .i1 (i1_vec),
    .i2 ({N_CELLS{mode_q}}),
    .o  (cell_out)
  );

  assign last_round = (rnd_cnt == (mode_q ? RW'(ROUNDS_PUF - 1) : RW'(ROUNDS_RND - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    t_en = 1'b0;
    case (state)
      IDLE:    if (start) nxt = ARM;
      ARM:     nxt = EXCITE;            // T low clears the latches
      EXCITE: begin
        t_en = 1'b1;
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) nxt = CAPTURE;
      end
      CAPTURE: begin
        t_en = 1'b1;
        nxt  = last_round ? DONE : ARM;
      end
      DONE:    if (ack) nxt = IDLE;     // ack wins over a concurrent start
      default: nxt = IDLE;
    endcase
  end

  // Two-flop synchroniser per cell; SETTLE_CYCLES >= 2 guarantees sync2
  // reflects the excited cell by the CAPTURE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= cell_out;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= 1'b0;
      mask_q     <= '0;
      chal_q     <= '0;
      data       <= '0;
      rnd_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode;
          mask_q  <= mask;
          chal_q  <= challenge;
          data    <= '0;
          rnd_cnt <= '0;
        end
        ARM:    settle_cnt <= '0;
        EXCITE: settle_cnt <= settle_cnt + SW'(1);
        CAPTURE: begin
          // Shift via a wide concat so OUT_WIDTH == N_CELLS needs no slice.
          if (mode_q) begin
            data   <= OUT_WIDTH'({data, sync2});
            chal_q <= {chal_q[N_CELLS-2:0], chal_q[N_CELLS-1]};
          end else begin
            data   <= OUT_WIDTH'({data, ^sync2});
          end
          rnd_cnt <= rnd_cnt + RW'(1);
        end
        default: ;
      endcase
    end
  end

  // valid follows DONE by one edge, which is also where busy drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      busy  <= (state == IDLE && start) || state == ARM || state == EXCITE || state == CAPTURE;
      valid <= (state == DONE);
    end
  end

endmodule

// File: doc/entropy_array_sampler.md
# entropy_array_sampler

Parametrised successor to the single XOR-latch entropy cell. The block instantiates `N_CELLS` entropy cells and drives their T/I1/I2 inputs from a round-based state machine. It synchronises and captures the cell outputs, then assembles an `OUT_WIDTH`-bit word in one of two modes: random (TRNG) or challenge-response (PUF). It sits inside the TRNG user peripheral, between the register interface and the cell array.

## Interface
- `N_CELLS`, 8: number of entropy cells; ≥2.
- `OUT_WIDTH`, 32: result width; must be a multiple of `N_CELLS`.
- `SETTLE_CYCLES`, 4: cycles T is held high per round before capture; ≥2.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `mode` in 1: 0 = random, 1 = PUF; sampled at start.
- `challenge` in N_CELLS: PUF challenge; sampled at start.
- `mask` in N_CELLS: random-mode cell enable; sampled at start.
- `ack` in 1: consumer acknowledge of `data`.
- `busy` out 1: high from the cycle after an accepted start until DONE is entered.
- `valid` out 1: `data` holds a complete result.
- `data` out OUT_WIDTH: result word.

## Operation
- Per-cell drive: T_i = `t_en` (FSM-driven, common to all cells); I2_i = latched mode.
  - Random mode: I1_i = latched mask[i].
  - PUF mode: I1_i = working challenge register bit i.
- Cell outputs pass through a 2-flop synchroniser per cell before capture.
- Rounds: random mode runs `OUT_WIDTH` rounds; PUF mode runs `OUT_WIDTH/N_CELLS` rounds. A round counter sized to hold `OUT_WIDTH` counts rounds.
- FSM states:
  - IDLE: `t_en`=0. On `start`, latch mode, mask and challenge; clear `data` and the round counter; go to ARM.
  - ARM (1 cycle): `t_en`=0, which resets the latches; go to EXCITE.
  - EXCITE: `t_en`=1 for exactly `SETTLE_CYCLES` cycles, tracked by a settle counter; go to CAPTURE.
  - CAPTURE (1 cycle, `t_en`=1):
    - Random mode: bit = XOR of synchronised outputs of all cells; `data <= {data[OUT_WIDTH-2:0], bit}`.
    - PUF mode: `data <= {data[OUT_WIDTH-N_CELLS-1:0], sync_out}`, then rotate the working challenge left by 1.
    - Increment the round counter. If this was the last round, go to DONE; otherwise go to ARM.
  - DONE: `valid`=1, `t_en`=0. On `ack`, clear `valid` and go to IDLE. `data` is retained until the next accepted start.
- Boundary conditions:
  - `start` outside IDLE is ignored. This includes DONE: if `start` and `ack` arrive in the same cycle in DONE, only `ack` acts.
  - `ack` outside DONE is ignored.
  - Random mode with `mask`=0 yields `data`=0.
  - Changes to `mode`, `mask` or `challenge` after start have no effect on the running conversion.
  - `rst` at any time, including mid-round, forces IDLE immediately. All counters, registers and outputs clear, and `t_en`=0.

## Timing
- Reset values: `busy`=0, `valid`=0, `data`=0, `t_en`=0, state IDLE.
- Each round takes `SETTLE_CYCLES`+2 cycles.
- Latency: `valid` rises ROUNDS×(`SETTLE_CYCLES`+2)+1 cycles after the clock edge that samples `start`.
  - Default random mode: 32×6+1 = 193 cycles.
  - Default PUF mode: 4×6+1 = 25 cycles.
- `busy` and `valid` are never high together. `busy` falls in the same edge that `valid` rises.
- `valid` falls on the edge after `ack` is sampled. A new start is accepted one cycle later, from IDLE.
- All outputs are registered.

## Test plan
For these scenarios the cell uses its behavioural model: output = T & I1.
- Reset: assert `rst` asynchronously mid-EXCITE -> `busy`, `valid`, `data` and all T drive go to 0 without waiting for a clock edge; the FSM is in IDLE after deassertion.
- Random mode, `mask`=8'h07, pulse `start` -> `valid` rises exactly 193 cycles later with `data`=32'hFFFF_FFFF; `busy` is high throughout the conversion.
- Random mode, `mask`=8'h03 (even parity) -> `data`=32'h0000_0000. With `mask`=8'h00 -> `data`=32'h0000_0000.
- PUF mode, `challenge`=8'hA5 -> `valid` after 25 cycles with `data`=32'hA54B_962D, reflecting the per-round left rotation of the challenge.
- Handshake:
  - Pulse `start` while `busy` -> ignored; the result is unchanged.
  - Hold `valid` for 10 cycles without `ack` -> `data` is stable.
  - Assert `ack` and `start` together -> `valid` drops and no new conversion begins; a later `start` begins a new conversion.
- Monitor check: T to every cell is low for exactly 1 cycle between rounds and high for exactly `SETTLE_CYCLES`+1 cycles per round.
